// File: rtl/btn_mmio.sv
// Memory-mapped push-button peripheral: synchronises and debounces five raw
// button pins, latches press/release events and exposes them on the CPU data bus.
module btn_mmio #(
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic        enabler,
    input  logic        write_enabler,
    input  logic [31:0] addr,
    input  logic [3:0]  select,
    input  logic [31:0] data_input,
    output logic [31:0] data_output,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [12:0]      VALID_BITS = 13'h1F1F;

    logic [4:0]       sync1;
    logic [4:0]       s;
    logic [4:0]       state;
    logic [CNT_W-1:0] cnt [5];
    logic [4:0]       accept;
    logic [4:0]       press;
    logic [4:0]       rel;
    logic [2:0]       press_cnt;
    logic [12:0]      event_r;
    logic [12:0]      ctrl_r;
    logic [15:0]      count_r;
    logic             hit;
    logic             wr;
    logic             rd;
    logic [1:0]       reg_sel;
    logic [12:0]      lane_mask;
    logic [12:0]      ev_clr;
    logic [12:0]      ev_set;
    logic             cnt_clr;
    logic             unused_ok;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr        = enabler && write_enabler && hit;
    assign rd        = enabler && !write_enabler && hit;
    assign reg_sel   = addr[3:2];
    assign lane_mask = {{5{select[1]}}, {8{select[0]}}} & VALID_BITS;
    assign ev_clr    = (wr && reg_sel == 2'd1) ? (data_input[12:0] & lane_mask) : 13'h0;
    assign ev_set    = {3'b000, rel, 3'b000, press};
    assign cnt_clr   = wr && (reg_sel == 2'd3) && (select != 4'b0000);
    assign unused_ok = &{1'b0, addr[1:0], data_input[31:13]};

    // A level change is accepted on the cycle its stability count completes.
    always_comb begin
        accept    = '0;
        press_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            accept[i] = (s[i] != state[i]) && (cnt[i] == CNT_LAST);
        end
        press = accept & s;
        rel   = accept & ~s;
        for (int i = 0; i < 5; i++) begin
            press_cnt = press_cnt + {2'b00, press[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
            state <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn;
            s     <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (s[i] == state[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    state[i] <= s[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // New events are OR-ed in after the clear so a same-cycle set survives W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_r <= '0;
            ctrl_r  <= '0;
            count_r <= '0;
            irq     <= 1'b0;
        end else begin
            event_r <= (event_r & ~ev_clr) | ev_set;
            if (wr && reg_sel == 2'd2) begin
                ctrl_r <= (ctrl_r & ~lane_mask) | (data_input[12:0] & lane_mask);
            end
            count_r <= (cnt_clr ? 16'h0000 : count_r) + {13'h0000, press_cnt};
            irq     <= |(event_r & ctrl_r);
        end
    end

    always_comb begin
        data_output = 32'h0;
        if (rd) begin
            case (reg_sel)
                2'd0: data_output = {27'h0, state};
                2'd1: data_output = {19'h0, event_r};
                2'd2: data_output = {19'h0, ctrl_r};
                2'd3: data_output = {16'h0, count_r};
                default: data_output = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_mmio.sv
// Scoreboard bench for btn_mmio: stimulus pushes expected bus/irq values, a
// negedge monitor pops and compares them against the live outputs.
module tb_btn_mmio;

    localparam logic [31:0] A_STATE = 32'h1000_0000;
    localparam logic [31:0] A_EVENT = 32'h1000_0004;
    localparam logic [31:0] A_CTRL  = 32'h1000_0008;
    localparam logic [31:0] A_COUNT = 32'h1000_000C;

    logic        clk;
    logic        rst;
    logic [4:0]  btn;
    logic [4:0]  btn_f;
    logic        enabler;
    logic        write_enabler;
    logic [31:0] addr;
    logic [3:0]  select;
    logic [31:0] data_input;
    logic [31:0] data_output;
    logic [31:0] data_output_f;
    logic        irq;
    logic        irq_f;

    string       name_q[$];
    logic [31:0] exp_q[$];
    int          kind_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    btn_mmio #(.BASE_ADDR(32'h1000_0000), .DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .btn(btn), .enabler(enabler),
        .write_enabler(write_enabler), .addr(addr), .select(select),
        .data_input(data_input), .data_output(data_output), .irq(irq)
    );

    // Short debounce instance so the COUNT wrap fits in a small cycle budget.
    btn_mmio #(.BASE_ADDR(32'h1000_0000), .DEBOUNCE_CYCLES(1), .CNT_W(20)) dut_fast (
        .clk(clk), .rst(rst), .btn(btn_f), .enabler(enabler),
        .write_enabler(write_enabler), .addr(addr), .select(select),
        .data_input(data_input), .data_output(data_output_f), .irq(irq_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] expv, input int kind);
        logic [31:0] act;
        n_checks++;
        if (kind == 2) begin
            act = {31'h0, irq};
        end else if (!(enabler && !write_enabler)) begin
            n_fail++;
            $display("[TB] FAIL %s: no read presented on the bus, expected %h", nm, expv);
            return;
        end else begin
            act = (kind == 1) ? data_output_f : data_output;
        end
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        while (name_q.size() > 0) begin
            checkOutput(name_q.pop_front(), exp_q.pop_front(), kind_q.pop_front());
        end
    end

    task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] sel, input string nm,
                                 input logic [31:0] expv, input int kind);
        enabler       = 1'b1;
        write_enabler = wr;
        addr          = a;
        data_input    = d;
        select        = sel;
        if (!wr) begin
            name_q.push_back(nm);
            exp_q.push_back(expv);
            kind_q.push_back(kind);
        end
        tick();
        enabler       = 1'b0;
        write_enabler = 1'b0;
        select        = 4'b0000;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        applyStimulus(1'b1, a, d, sel, "", 32'h0, 0);
    endtask

    task automatic bus_read(input logic [31:0] a, input string nm, input logic [31:0] expv);
        applyStimulus(1'b0, a, 32'h0, 4'b0000, nm, expv, 0);
    endtask

    task automatic bus_read_f(input logic [31:0] a, input string nm, input logic [31:0] expv);
        applyStimulus(1'b0, a, 32'h0, 4'b0000, nm, expv, 1);
    endtask

    task automatic probe_irq(input string nm, input logic expv);
        name_q.push_back(nm);
        exp_q.push_back({31'h0, expv});
        kind_q.push_back(2);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        btn = '0; btn_f = '0; enabler = 0; write_enabler = 0;
        addr = '0; select = '0; data_input = '0; rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Clean press: accepted exactly 6 edges after the raw edge, irq one edge later.
        bus_write(A_CTRL, 32'h0000_0001, 4'b0001);
        btn = 5'b00001;
        repeat (4) tick();
        bus_read(A_STATE, "state_e4", 32'h0);
        bus_read(A_STATE, "state_e5", 32'h0);
        probe_irq("irq_e6", 1'b0);
        bus_read(A_STATE, "state_e6", 32'h1);
        probe_irq("irq_e7", 1'b1);
        bus_read(A_EVENT, "event_e7", 32'h1);
        bus_read(A_COUNT, "count_e8", 32'h1);

        btn = 5'b00000;
        repeat (10) tick();
        bus_read(A_EVENT, "event_press_release", 32'h0000_0101);
        bus_read(A_STATE, "state_released", 32'h0);

        // W1C with byte lane 0 only clears the press bit.
        bus_write(A_EVENT, 32'h0000_0101, 4'b0001);
        bus_read(A_EVENT, "event_w1c_lane0", 32'h0000_0100);
        probe_irq("irq_after_clear", 1'b0);
        bus_read(A_COUNT, "count_after_clear", 32'h1);

        // Clear lands on the same edge as a new press: set wins.
        btn = 5'b00001;
        repeat (5) tick();
        bus_write(A_EVENT, 32'h0000_0101, 4'b0001);
        bus_read(A_EVENT, "event_set_wins", 32'h0000_0101);
        bus_read(A_COUNT, "count_second_press", 32'h2);
        bus_read(A_CTRL, "ctrl_before_reset", 32'h1);

        rst = 1'b1;
        btn = 5'b00000;
        probe_irq("irq_in_reset", 1'b0);
        bus_read(A_STATE, "reset_state", 32'h0);
        bus_read(A_EVENT, "reset_event", 32'h0);
        bus_read(A_CTRL, "reset_ctrl", 32'h0);
        bus_read(A_COUNT, "reset_count", 32'h0);
        rst = 1'b0;
        tick();

        // Three-cycle pulses never reach the four-cycle debounce threshold.
        for (int p = 0; p < 4; p++) begin
            btn = 5'b00100;
            repeat (3) tick();
            btn = 5'b00000;
            repeat (3) tick();
        end
        repeat (4) tick();
        bus_read(A_STATE, "bounce_state", 32'h0);
        bus_read(A_EVENT, "bounce_event", 32'h0);
        bus_read(A_COUNT, "bounce_count", 32'h0);
        btn = 5'b00100;
        repeat (10) tick();
        bus_read(A_STATE, "stable_state", 32'h4);
        bus_read(A_EVENT, "stable_event", 32'h4);
        bus_read(A_COUNT, "stable_count", 32'h1);

        bus_write(A_CTRL, 32'hFFFF_FFFF, 4'b1111);
        bus_read(A_CTRL, "ctrl_full_write", 32'h0000_1F1F);
        bus_write(A_CTRL, 32'h0000_0000, 4'b0010);
        bus_read(A_CTRL, "ctrl_lane1_write", 32'h0000_001F);
        bus_read(32'h1000_0010, "read_outside_window", 32'h0);
        bus_write(32'h1000_0018, 32'h0000_0000, 4'b1111);
        bus_read(A_CTRL, "ctrl_after_outside_write", 32'h0000_001F);
        bus_write(A_STATE, 32'h0000_0000, 4'b1111);
        bus_read(A_STATE, "state_write_ignored", 32'h4);
        bus_write(A_COUNT, 32'hFFFF_FFFF, 4'b0000);
        bus_read(A_COUNT, "count_no_lane_kept", 32'h1);
        bus_write(A_COUNT, 32'h0000_0000, 4'b0100);
        bus_read(A_COUNT, "count_cleared", 32'h0);

        btn = 5'b00000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // 13106 rounds of five presses plus one round of four gives 0xFFFE.
        for (int r = 0; r < 13106; r++) begin
            btn_f = 5'h1F;
            tick();
            btn_f = 5'h00;
            tick();
        end
        btn_f = 5'h0F;
        tick();
        btn_f = 5'h00;
        repeat (4) tick();
        bus_read_f(A_COUNT, "count_preload", 32'h0000_FFFE);
        btn_f = 5'h18;
        tick();
        btn_f = 5'h00;
        repeat (4) tick();
        bus_read_f(A_COUNT, "count_wrap", 32'h0000_0000);
        bus_read_f(A_EVENT, "fast_event_all", 32'h0000_1F1F);

        btn_f = 5'h01;
        tick();
        tick();
        bus_write(A_COUNT, 32'h0000_0000, 4'b0001);
        bus_read_f(A_COUNT, "count_clear_with_press", 32'h1);
        bus_write(A_COUNT, 32'h0000_0000, 4'b0001);
        bus_read_f(A_COUNT, "count_clear_plain", 32'h0);

        tick();
        tick();
        if (name_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries expected 0", name_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
